// File: rtl/gpio_dbus_master.sv
// gpio_dbus_master
// Initiator side of the peripheral data bus. Accepts one core load/store at a
// time, decodes it onto one of five GPIO-window responders (A, B, C, switches,
// LEDs), drives the registered bus request and waits for the responder ack.
// A saturating timeout counter converts a hung access into an error response.
// Illegal requests (outside the window, misaligned, no byte enables, or a write
// to the read-only switch block) never reach the bus and are answered with an
// error on the following cycle.
module gpio_dbus_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          TO_W           = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [3:0]  core_be_i,
  output logic        core_ready_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  output logic        gpioA_sel_o,
  output logic        gpioB_sel_o,
  output logic        gpioC_sel_o,
  output logic        gpsw_sel_o,
  output logic        gpled_sel_o,
  output logic        peri_req_o,
  output logic        peri_we_o,
  output logic [7:0]  peri_addr_o,
  output logic [31:0] peri_wdata_o,
  output logic [3:0]  peri_be_o,
  input  logic        peri_ack_i,
  input  logic [31:0] peri_rdata_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Last legal byte offset of the five 0x100-byte targets.
  localparam logic [32:0] WIN_LAST = 33'h0_0000_04FF;
  // Counter value seen during the final allowed ACCESS cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYCLES);

  // Target index 3 is the switch block, which is read-only.
  localparam logic [2:0] IDX_GPSW = 3'd3;

  logic [1:0]      state;
  logic [4:0]      sel_q;
  logic            req_q;
  logic            we_q;
  logic [7:0]      addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [TO_W-1:0] to_cnt;

  logic            dec_legal;
  logic [4:0]      dec_sel;
  logic            to_hit;

  // Returns {legal, one-hot select}. The subtraction is done one bit wider so
  // that addresses below the base wrap to a huge offset and fail the range test.
  function automatic logic [5:0] decode_target(input logic [31:0] addr,
                                               input logic        we,
                                               input logic [3:0]  be);
    logic [32:0] off;
    logic [2:0]  idx;
    logic [4:0]  sel;
    logic        legal;
    off   = {1'b0, addr} - {1'b0, BASE_ADDR};
    idx   = off[10:8];
    sel   = 5'b0;
    legal = (off <= WIN_LAST) && (addr[1:0] == 2'b00) && (be != 4'b0000);
    if (legal && we && (idx == IDX_GPSW)) begin
      legal = 1'b0;
    end
    if (legal) begin
      sel = 5'b00001 << idx;
    end
    return {legal, sel};
  endfunction

  // Address decode of the live core request (only used while IDLE).
  always_comb begin
    {dec_legal, dec_sel} = decode_target(core_addr_i, core_we_i, core_be_i);
  end

  assign to_hit = (to_cnt == TO_LAST);

  // Transaction FSM with request latch, responder wait and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_q   <= 5'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      to_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (core_req_i) begin
            we_q    <= core_we_i;
            addr_q  <= core_addr_i[7:0];
            wdata_q <= core_wdata_i;
            be_q    <= core_be_i;
            if (dec_legal) begin
              sel_q <= dec_sel;
              req_q <= 1'b1;
              state <= ST_ACCESS;
            end else begin
              rdata_q <= 32'h0;
              err_q   <= 1'b1;
              state   <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (to_cnt != TO_SAT) begin
            to_cnt <= to_cnt + 1'b1;
          end
          // Ack takes priority over a timeout landing in the same cycle.
          if (peri_ack_i) begin
            rdata_q <= we_q ? 32'h0 : peri_rdata_i;
            err_q   <= 1'b0;
            sel_q   <= 5'b0;
            req_q   <= 1'b0;
            state   <= ST_RESP;
          end else if (to_hit) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            sel_q   <= 5'b0;
            req_q   <= 1'b0;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          to_cnt <= '0;
          state  <= ST_IDLE;
        end
        default: begin
          sel_q  <= 5'b0;
          req_q  <= 1'b0;
          to_cnt <= '0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign core_ready_o  = (state == ST_IDLE);
  assign core_rvalid_o = (state == ST_RESP);
  // Response fields are only meaningful with the strobe; keep them quiet otherwise.
  assign core_rdata_o  = core_rvalid_o ? rdata_q : 32'h0;
  assign core_err_o    = core_rvalid_o & err_q;

  assign gpioA_sel_o  = sel_q[0];
  assign gpioB_sel_o  = sel_q[1];
  assign gpioC_sel_o  = sel_q[2];
  assign gpsw_sel_o   = sel_q[3];
  assign gpled_sel_o  = sel_q[4];

  assign peri_req_o   = req_q;
  assign peri_we_o    = we_q;
  assign peri_addr_o  = addr_q;
  assign peri_wdata_o = wdata_q;
  assign peri_be_o    = be_q;

endmodule

// File: tb/tb_gpio_dbus_master.sv
// Testbench for gpio_dbus_master: directed vector table, hand-written corner
// sequences (reset, spurious ack, reset mid-access) and randomized transactions
// checked against a transaction-level reference model.
module tb_gpio_dbus_master;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          TO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_be;
  logic        core_ready, core_rvalid, core_err;
  logic [31:0] core_rdata;
  logic        gpioA_sel, gpioB_sel, gpioC_sel, gpsw_sel, gpled_sel;
  logic        peri_req, peri_we;
  logic [7:0]  peri_addr;
  logic [31:0] peri_wdata;
  logic [3:0]  peri_be;
  logic        peri_ack;
  logic [31:0] peri_rdata;
  logic [4:0]  sel_vec;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign sel_vec = {gpled_sel, gpsw_sel, gpioC_sel, gpioB_sel, gpioA_sel};

  gpio_dbus_master #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_be_i(core_be),
    .core_ready_o(core_ready), .core_rvalid_o(core_rvalid),
    .core_rdata_o(core_rdata), .core_err_o(core_err),
    .gpioA_sel_o(gpioA_sel), .gpioB_sel_o(gpioB_sel), .gpioC_sel_o(gpioC_sel),
    .gpsw_sel_o(gpsw_sel), .gpled_sel_o(gpled_sel),
    .peri_req_o(peri_req), .peri_we_o(peri_we), .peri_addr_o(peri_addr),
    .peri_wdata_o(peri_wdata), .peri_be_o(peri_be),
    .peri_ack_i(peri_ack), .peri_rdata_i(peri_rdata)
  );

  // k = ack delay: ack is driven in cycle 1+k after accept; k<0 means never.
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          k;
    logic [31:0] ack_rdata;
    int          exp_rv;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_sel;
    int          exp_sel_cyc;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: derives the outcome of one transaction from the bus rules.
  function automatic txn_t model(input txn_t t);
    txn_t   r;
    longint a;
    longint tgt;
    bit     legal;
    r     = t;
    a     = longint'(t.addr);
    tgt   = (a - longint'(BASE)) / 256;
    legal = (a >= longint'(BASE)) && (a < longint'(BASE) + 5 * 256) &&
            (t.addr % 4 == 0) && (t.be != 0) && !(t.we && tgt == 3);
    if (!legal) begin
      r.exp_rv = 1; r.exp_err = 1'b1; r.exp_rdata = 32'h0;
      r.exp_sel = 5'b0; r.exp_sel_cyc = 0;
    end else begin
      r.exp_sel = 5'b0;
      r.exp_sel[int'(tgt)] = 1'b1;
      if (t.k >= 0 && t.k < TO) begin
        r.exp_rv = 2 + t.k; r.exp_err = 1'b0;
        r.exp_rdata = t.we ? 32'h0 : t.ack_rdata;
        r.exp_sel_cyc = t.k + 1;
      end else begin
        r.exp_rv = TO + 1; r.exp_err = 1'b1; r.exp_rdata = 32'h0;
        r.exp_sel_cyc = TO;
      end
    end
    return r;
  endfunction

  // Runs one transaction starting in IDLE; ends at the cycle after rvalid.
  task automatic run_txn(input txn_t t, input string name);
    int  cyc, rv_cyc, sel_cnt, bad_sel, ready_hi;
    bit  done;
    logic        got_err;
    logic [31:0] got_rdata;
    core_req = 1'b1; core_we = t.we; core_addr = t.addr;
    core_wdata = t.wdata; core_be = t.be;
    @(negedge clk);
    chk({name, " ready@accept"}, 32'(core_ready), 32'd1);
    @(posedge clk); #1;
    cyc = 1; done = 0; rv_cyc = -1; sel_cnt = 0; bad_sel = 0; ready_hi = 0;
    got_err = 1'bx; got_rdata = 'x;
    while (!done && cyc < 40) begin
      // Junk core traffic while busy must be ignored.
      core_req   = (cyc <= t.exp_rv) ? 1'($urandom_range(0, 1)) : 1'b0;
      core_we    = 1'($urandom_range(0, 1));
      core_addr  = BASE + 32'($urandom_range(0, 4) * 256);
      core_wdata = $urandom;
      core_be    = 4'hF;
      peri_ack   = (t.k >= 0) && (cyc == 1 + t.k);
      peri_rdata = peri_ack ? t.ack_rdata : $urandom;
      @(negedge clk);
      if (t.exp_sel != 0 && sel_vec == t.exp_sel && peri_req) sel_cnt++;
      else if (sel_vec != 0 || peri_req) bad_sel++;
      if (core_ready) ready_hi++;
      if (cyc == 1 && t.exp_sel != 0) begin
        chk({name, " peri_we"},    32'(peri_we),    32'(t.we));
        chk({name, " peri_addr"},  32'(peri_addr),  32'(t.addr[7:0]));
        chk({name, " peri_be"},    32'(peri_be),    32'(t.be));
        chk({name, " peri_wdata"}, peri_wdata,      t.wdata);
      end
      if (core_rvalid) begin
        done = 1; rv_cyc = cyc; got_err = core_err; got_rdata = core_rdata;
      end
      @(posedge clk); #1;
      peri_ack = 1'b0;
      cyc++;
    end
    core_req = 1'b0;
    chk({name, " rvalid cycle"}, 32'(rv_cyc),    32'(t.exp_rv));
    chk({name, " err"},          32'(got_err),   32'(t.exp_err));
    chk({name, " rdata"},        got_rdata,      t.exp_rdata);
    chk({name, " sel cycles"},   32'(sel_cnt),   32'(t.exp_sel_cyc));
    chk({name, " stray sel"},    32'(bad_sel),   32'd0);
    chk({name, " ready busy"},   32'(ready_hi),  32'd0);
  endtask

  txn_t tbl[11];

  initial begin
    // Directed vectors: addr, we, be, wdata, k, ack_rdata, rv, err, rdata, sel, sel_cycles
    tbl[0]  = '{32'h4000_0104, 1'b0, 4'hF, 32'h0,        2,  32'h0000_00A5, 4,  1'b0, 32'h0000_00A5, 5'b00010, 3};
    tbl[1]  = '{32'h4000_0400, 1'b1, 4'hF, 32'h0000_FFFF, 0,  32'h1111_2222, 2,  1'b0, 32'h0,        5'b10000, 1};
    tbl[2]  = '{32'h4000_0200, 1'b0, 4'hF, 32'h0,        -1, 32'h0,         17, 1'b1, 32'h0,        5'b00100, 16};
    tbl[3]  = '{32'h4000_0500, 1'b0, 4'hF, 32'h0,        0,  32'h0,         1,  1'b1, 32'h0,        5'b00000, 0};
    tbl[4]  = '{32'h4000_0002, 1'b0, 4'hF, 32'h0,        0,  32'h0,         1,  1'b1, 32'h0,        5'b00000, 0};
    tbl[5]  = '{32'h4000_0300, 1'b1, 4'hF, 32'h5,        0,  32'h0,         1,  1'b1, 32'h0,        5'b00000, 0};
    tbl[6]  = '{32'h4000_0300, 1'b0, 4'hF, 32'h0,        1,  32'h0000_1234, 3,  1'b0, 32'h0000_1234, 5'b01000, 2};
    tbl[7]  = '{32'h4000_0000, 1'b0, 4'hF, 32'h0,        15, 32'hDEAD_BEEF, 17, 1'b0, 32'hDEAD_BEEF, 5'b00001, 16};
    tbl[8]  = '{32'h4000_0004, 1'b0, 4'h0, 32'h0,        0,  32'h0,         1,  1'b1, 32'h0,        5'b00000, 0};
    tbl[9]  = '{32'h3FFF_FFFC, 1'b0, 4'hF, 32'h0,        0,  32'h0,         1,  1'b1, 32'h0,        5'b00000, 0};
    tbl[10] = '{32'h4000_04FC, 1'b1, 4'h3, 32'hCAFE_0001, 0,  32'h7777_7777, 2,  1'b0, 32'h0,        5'b10000, 1};

    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0;
    core_wdata = 32'h0; core_be = 4'h0; peri_ack = 1'b0; peri_rdata = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset ready",  32'(core_ready),  32'd1);
    chk("reset rvalid", 32'(core_rvalid), 32'd0);
    chk("reset sel",    32'(sel_vec),     32'd0);
    chk("reset req",    32'(peri_req),    32'd0);
    chk("reset we",     32'(peri_we),     32'd0);
    chk("reset rdata",  core_rdata,       32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Spurious ack while idle must not produce a response.
    begin
      int rv_seen;
      rv_seen = 0;
      peri_ack = 1'b1; peri_rdata = 32'h9999_9999;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (core_rvalid || !core_ready) rv_seen++;
        @(posedge clk); #1;
        peri_ack = 1'b0;
      end
      chk("idle ack ignored", 32'(rv_seen), 32'd0);
    end

    // Reset during ACCESS drops the transaction.
    begin
      int rv_seen;
      rv_seen = 0;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h4000_0208; core_be = 4'hF;
      @(posedge clk); #1;
      core_req = 1'b0;
      @(negedge clk);
      chk("rst-mid sel before", 32'(sel_vec), 32'b00100);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst-mid sel after",   32'(sel_vec),    32'd0);
      chk("rst-mid req after",   32'(peri_req),   32'd0);
      chk("rst-mid ready after", 32'(core_ready), 32'd1);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (core_rvalid) rv_seen++;
      end
      chk("rst-mid no rvalid", 32'(rv_seen), 32'd0);
      @(posedge clk); #1;
      run_txn('{32'h4000_0108, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_F00D, 3, 1'b0,
                32'h0BAD_F00D, 5'b00010, 2}, "post-rst read");
    end

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      txn_t t;
      int   region;
      region      = $urandom_range(0, 7);
      t.addr      = (region == 7) ? (BASE - 32'($urandom_range(1, 64) * 4))
                                  : (BASE + 32'(region * 256) + 32'($urandom_range(0, 63) * 4));
      if ($urandom_range(0, 9) == 0) t.addr[1:0] = 2'($urandom_range(1, 3));
      t.we        = 1'($urandom_range(0, 1));
      t.be        = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      t.wdata     = $urandom;
      t.k         = $urandom_range(0, 20);
      t.ack_rdata = $urandom;
      t           = model(t);
      run_txn(t, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
